// File: rtl/alu_pkg.sv
// Shared ALU encodings: alu_ctrl codes driven by the ALU control decoder and
// consumed by alu_exec, plus the R-type funct codes that select them.
package alu_pkg;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned FUNCT_W = 6;

  typedef enum logic [CTRL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_MUL = 4'b1000,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [FUNCT_W-1:0] {
    FN_MUL = 6'h18,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2a
  } funct_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier. The final partial sum is exposed
// combinationally so the consumer can capture it on the last iteration edge.
module mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done_c,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  assign product_c = mplier[0] ? (acc + mcand) : acc;
  assign done_c    = busy && (cnt == CNT_W'(WIDTH - 1));

  // One partial product per cycle; busy drops on the WIDTH-th iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= PW'(a);
      mplier <= b;
    end else if (busy) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done_c) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative MUL,
// with valid/ready on both sides and a registered result/flag output.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned MSB = WIDTH - 1;

  state_e               state;
  alu_op_e              op;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_done_c;
  logic [2*WIDTH-1:0]   mul_prod_c;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     diff;
  logic                 ovf_add;
  logic                 ovf_sub;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;

  assign op        = alu_op_e'(alu_ctrl);
  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == ALU_MUL);

  assign sum     = src_a + src_b;
  assign diff    = src_a - src_b;
  assign ovf_add = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
  assign ovf_sub = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);

  // Single-cycle datapath; unknown codes (and MUL here) produce zero.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_NOR: alu_res = ~(src_a | src_b);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = ovf_add;
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = ovf_sub;
      end
      ALU_SLT: alu_res = WIDTH'(diff[MSB] ^ ovf_sub);
      default: ;
    endcase
  end

  mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .a         (src_a),
    .b         (src_b),
    .busy      (busy),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  // Handshake FSM and output register; a same-edge accept overrides the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == ALU_MUL) begin
              state <= S_MUL;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
            end
          end
        end
        S_MUL: begin
          if (mul_done_c) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            result    <= mul_prod_c[MSB:0];
            zero      <= (mul_prod_c[MSB:0] == '0);
            overflow  <= |mul_prod_c[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected results are queued at issue time
// and compared whenever an output beat is consumed.
module tb_alu_exec;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  alu_exec #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    e.res = '0;
    e.v   = 1'b0;
    s     = '0;
    p     = '0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        s     = {a[31], a} + {b[31], b};
        e.res = s[31:0];
        e.v   = s[32] ^ s[31];
      end
      4'b0110: begin
        s     = {a[31], a} - {b[31], b};
        e.res = s[31:0];
        e.v   = s[32] ^ s[31];
      end
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin
        p     = 64'(a) * 64'(b);
        e.res = p[31:0];
        e.v   = |p[63:32];
      end
      default: ;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_timeout", 64'(in_ready), 64'(1));
    else sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: a beat transfers on the edge following valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", 64'(result), 64'(e.res));
        chk("sb_zero", 64'(zero), 64'(e.z));
        chk("sb_overflow", 64'(overflow), 64'(e.v));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int         n;
    logic [3:0] ops [11] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'h4, 4'h9, 4'hF, 4'h8};
    logic [3:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_ctrl  = 4'h0;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    next_cycle();

    // Arithmetic corner cases, full-rate issue.
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    chk("add_ovf_latency1", 64'(out_valid), 64'(1));
    chk("add_ovf_result", 64'(result), 64'(32'h8000_0000));
    next_cycle();
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF);
    issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(4'b0110, 32'h8000_0000, 32'h0000_0001);

    // MUL with high-half overflow; inputs toggled freely while iterating.
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("mul_in_ready_low", 64'(in_ready), 64'(0));
      in_valid = 1'($urandom_range(0, 1));
      alu_ctrl = 4'($urandom_range(0, 15));
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", 64'(n), 64'(32));
    chk("mul_valid_at_done", 64'(out_valid), 64'(1));
    next_cycle();

    issue(4'b1000, 32'd12345, 32'd678);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("mul2_busy_cycles", 64'(n), 64'(32));
    chk("mul2_result", 64'(result), 64'(32'd8369910));
    next_cycle();

    // Backpressure hold, then same-edge drain + accept.
    out_ready = 1'b0;
    issue(4'b1100, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_result", 64'(result), 64'(32'hFFFF_FFFF));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    next_cycle();
    out_ready = 1'b1;
    issue(4'b0010, 32'd3, 32'd4);
    @(negedge clk);
    chk("b2b_out_valid", 64'(out_valid), 64'(1));
    chk("b2b_result", 64'(result), 64'(7));
    next_cycle();

    // Reset ten cycles into a MUL aborts it without emitting a result.
    issue(4'b1000, 32'd3, 32'd5);
    repeat (9) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort_no_result", 64'(n), 64'(0));
    next_cycle();

    // Reset wins over a simultaneous request.
    rst      = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 4'b0010;
    src_a    = 32'd1;
    src_b    = 32'd1;
    next_cycle();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_vs_req_valid", 64'(out_valid), 64'(0));
    next_cycle();

    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    @(negedge clk);
    chk("and_result", 64'(result), 64'(32'h0000_F000));
    next_cycle();

    // Random mix with occasional consumer stalls, including unknown codes.
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 10)];
      a  = $urandom();
      b  = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        a = a >> $urandom_range(0, 31);
        b = b >> $urandom_range(0, 31);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) next_cycle();
      out_ready = 1'b1;
      issue(op, a, b);
    end

    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus two operands and produces a registered result, zero flag and overflow flag.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) complete with latency 1.
- New code MUL runs an iterative shift-add multiplier; valid/ready handshakes on both sides let the datapath stall around it.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- alu_ctrl  input  4  op code: AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111 NOR=1100 MUL=1000
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/SUB) or product high half nonzero (MUL); 0 otherwise
- busy  output  1  multiplier iterating

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE, out_valid=0, result=0, zero=0, overflow=0, busy=0, counter=0.
  - in_ready=1 in the cycle after reset deasserts.
- Accept rule: in_ready = (state==IDLE) && (!out_valid || out_ready). A request is accepted on a rising edge where in_valid && in_ready.
- Single-cycle ops:
  - Output register loads at the accept edge; out_valid=1 from the next cycle (latency 1).
  - AND: a&b. OR: a|b. NOR: ~(a|b).
  - ADD: a+b mod 2^WIDTH; overflow = operand signs equal and result sign differs.
  - SUB: a-b mod 2^WIDTH; overflow = operand signs differ and result sign differs from a.
  - SLT: result = {0..., (a-b)[MSB] ^ ovf_sub}, i.e. a signed compare; overflow output = 0.
- Unknown alu_ctrl: treated as single-cycle; result=0, zero=1, overflow=0.
- MUL, states IDLE -> MUL -> IDLE:
  - Accept edge: latch multiplicand/multiplier, clear the 2*WIDTH accumulator, counter=0, busy=1.
  - Each MUL cycle: if multiplier LSB=1, add the shifted multiplicand; shift; counter++.
  - After exactly WIDTH iterations, load result = product[WIDTH-1:0] and overflow = |product[2W-1:W]; busy=0; state=IDLE.
  - out_valid rises WIDTH cycles after the accept edge. Operands are unsigned.
- zero is computed from the value loaded into result, in the same edge.
- Output hold: while out_valid && !out_ready, result, zero and overflow are frozen and in_ready=0.
- out_valid clears on an out_ready edge unless a new single-cycle op is accepted on that same edge. In that case it stays 1 with the new data, giving back-to-back throughput of 1/cycle.
- During MUL: in_ready=0. in_valid and alu_ctrl are ignored and may change freely.
- Before the MUL result is loaded, the previous result must have drained, which the accept rule already guarantees.
- Reset mid-MUL: the rst edge aborts the iteration and returns to the reset values. No result is emitted.
- Reset while out_valid=1 and out_ready=0: the result is dropped and out_valid=0.
- Simultaneous rst and in_valid: rst wins; the request is not accepted.

Decomposition:
- Shared package alu_pkg:
  - alu_ctrl encodings (AND, OR, ADD, SUB, SLT, NOR, MUL) and funct codes.
  - Imported by both the ALU control decoder and alu_exec, so the encodings have a single source.
  - MUL=1000 is added to the decoder's table in the same change.
- Sub-module mul_iter:
  - Shift-add multiplier with start/done, WIDTH parameter and a 2*WIDTH product output.
  - Holds its own counter; alu_exec owns the handshake FSM and the output register.

Test Plan:
- rst held 2 cycles, then released -> in_ready=1, out_valid=0, result=0, busy=0.
- ADD a=0x7FFFFFFF, b=0x00000001, out_ready=1 -> next cycle result=0x80000000, overflow=1, zero=0. SUB a=5, b=5 -> result=0, zero=1, overflow=0.
- SLT a=0xFFFFFFFF, b=0x00000001 -> result=1. SLT a=0x80000000, b=0x7FFFFFFF -> result=1. SLT a=1, b=0xFFFFFFFF -> result=0.
- MUL a=0x00010000, b=0x00010000 -> busy=1 for 32 cycles, in_ready=0 throughout; then result=0, zero=1, overflow=1. MUL a=12345, b=678 -> result=8369910, overflow=0.
- Backpressure: NOR a=0, b=0 with out_ready=0 for 5 cycles -> result=0xFFFFFFFF stable, out_valid=1, in_ready=0. Raise out_ready with a queued ADD 3+4 -> next result=7, out_valid never drops.
- rst asserted 10 cycles into a MUL -> next cycle out_valid=0, busy=0, in_ready=1. A subsequent AND 0xF0F0, 0xFF00 -> result=0xF000.
